// File: rtl/csr_wr_arb_if.sv
// Bundles the CSR write port arbiter's request, grant and status signals.
// Handshake: exu_we_i and excp_we_i are single-cycle write strobes with no
// ready path. exu is never backpressured; excp pressure is reported through
// stallreq_o and excp writes that cannot be stored are dropped and flagged
// on overflow_o. csr_we_o is a one-cycle strobe that csr_regs must accept.
interface csr_wr_arb_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          exu_we_i;
    logic [AW-1:0] exu_waddr_i;
    logic [DW-1:0] exu_wdata_i;
    logic          excp_we_i;
    logic [AW-1:0] excp_waddr_i;
    logic [DW-1:0] excp_wdata_i;
    logic [AW-1:0] rd_addr_i;
    logic          csr_we_o;
    logic [AW-1:0] csr_waddr_o;
    logic [DW-1:0] csr_wdata_o;
    logic          rd_hazard_o;
    logic          stallreq_o;
    logic          overflow_o;

    modport master (
        output exu_we_i, exu_waddr_i, exu_wdata_i,
        output excp_we_i, excp_waddr_i, excp_wdata_i, rd_addr_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o,
        input  rd_hazard_o, stallreq_o, overflow_o
    );

    modport slave (
        input  exu_we_i, exu_waddr_i, exu_wdata_i,
        input  excp_we_i, excp_waddr_i, excp_wdata_i, rd_addr_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o,
        output rd_hazard_o, stallreq_o, overflow_o
    );
endinterface

// File: rtl/csr_wr_arb.sv
// CSR write-port arbiter: exu writes always win, colliding excp writes wait
// in an in-order FIFO and drain when exu leaves the port idle.
module csr_wr_arb #(
    parameter int DEPTH = 4,
    parameter int AW    = 12,
    parameter int DW    = 32
) (
    input logic         clk,
    input logic         rst_n,
    csr_wr_arb_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          csr_we;
    logic [AW-1:0] csr_waddr;
    logic [DW-1:0] csr_wdata;
    logic          not_empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          hazard;

    // Grant decode: a pop happens whenever exu leaves the port free; excp must
    // queue behind exu or behind older queued entries, and a full FIFO only
    // accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        not_empty = (count != '0);
        pop       = !bus.exu_we_i && not_empty;
        push_req  = bus.excp_we_i && (bus.exu_we_i || not_empty);
        push      = push_req && ((count != FULL) || pop);
        drop      = push_req && !push;
    end

    // FIFO storage written at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else if (push) begin
            q_addr[wr_ptr] <= bus.excp_waddr_i;
            q_data[wr_ptr] <= bus.excp_wdata_i;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky record that an excp write was lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    // Registered write port: exu, then FIFO head, then excp bypass, else idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_we    <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
        end else if (bus.exu_we_i) begin
            csr_we    <= 1'b1;
            csr_waddr <= bus.exu_waddr_i;
            csr_wdata <= bus.exu_wdata_i;
        end else if (not_empty) begin
            csr_we    <= 1'b1;
            csr_waddr <= q_addr[rd_ptr];
            csr_wdata <= q_data[rd_ptr];
        end else if (bus.excp_we_i) begin
            csr_we    <= 1'b1;
            csr_waddr <= bus.excp_waddr_i;
            csr_wdata <= bus.excp_wdata_i;
        end else begin
            csr_we    <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
        end
    end

    // Read hazard: the read address hits a valid queued entry or the write
    // currently presented to csr_regs.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (q_addr[rd_ptr + PW'(i)] == bus.rd_addr_i)) begin
                hazard = 1'b1;
            end
        end
        if (csr_we && (csr_waddr == bus.rd_addr_i)) begin
            hazard = 1'b1;
        end
    end

    assign bus.csr_we_o    = csr_we;
    assign bus.csr_waddr_o = csr_waddr;
    assign bus.csr_wdata_o = csr_wdata;
    assign bus.rd_hazard_o = hazard;
    assign bus.stallreq_o  = not_empty | (bus.excp_we_i & bus.exu_we_i);
    assign bus.overflow_o  = overflow;
endmodule
